// File: rtl/galois_lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to an LFSR bit stream using its
// linear recurrence, then flywheels on the prediction and counts bit errors.
module galois_lfsr_checker #(
    parameter int unsigned            LFSR_WIDTH                 = 8,
    parameter int unsigned            LFSR_OUTPUT_BITS_PER_CLOCK = 1,
    parameter logic [LFSR_WIDTH-1:0]  TAPS                       = 8'h8E,
    parameter int unsigned            LOCK_COUNT                 = 16,
    parameter int unsigned            LOSS_WINDOW                = 64,
    parameter int unsigned            LOSS_THRESHOLD             = 8,
    parameter int unsigned            CNT_WIDTH                  = 32
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] in_bits,
    input  logic                                  in_valid,
    input  logic                                  clr_counts,
    output logic                                  locked,
    output logic [1:0]                            sync_state,
    output logic                                  bit_err,
    output logic [CNT_WIDTH-1:0]                  err_count,
    output logic [CNT_WIDTH-1:0]                  bit_count
);

    localparam int unsigned W      = LFSR_WIDTH;
    localparam int unsigned B      = LFSR_OUTPUT_BITS_PER_CLOCK;
    localparam int unsigned FILL_W = $clog2(W + 1);
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WB_W   = $clog2(LOSS_WINDOW + B + 1);
    localparam int unsigned WE_W   = $clog2(LOSS_THRESHOLD + B + 1);
    localparam int unsigned MIS_W  = $clog2(B + 1);
    localparam int unsigned CW1    = CNT_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [W-1:0]         hist, hist_d;
    logic [FILL_W-1:0]    fill, fill_d;
    logic [GOOD_W-1:0]    good, good_d;
    logic [WB_W-1:0]      win_bits, win_bits_d;
    logic [WE_W-1:0]      win_errs, win_errs_d;
    logic [MIS_W-1:0]     mis;
    logic                 pred;
    logic                 rx;
    logic [CW1-1:0]       bit_inc, err_inc;
    logic [CW1-1:0]       bit_sum, err_sum;
    logic [CNT_WIDTH-1:0] bit_count_d, err_count_d;
    logic                 bit_err_d;

    // Sync state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_HUNT;
        end else begin
            state <= state_d;
        end
    end

    // Serial MSB-first beat evaluation, next-state and counter updates.
    always_comb begin
        state_d     = state;
        hist_d      = hist;
        fill_d      = fill;
        good_d      = good;
        win_bits_d  = win_bits;
        win_errs_d  = win_errs;
        mis         = '0;
        pred        = 1'b0;
        rx          = 1'b0;
        bit_inc     = '0;
        err_inc     = '0;
        bit_err_d   = 1'b0;

        if (in_valid) begin
            for (int i = B - 1; i >= 0; i--) begin
                rx   = in_bits[i];
                pred = ^(hist_d & TAPS);
                case (state)
                    ST_HUNT: begin
                        hist_d = {hist_d[W-2:0], rx};
                        if (fill_d < FILL_W'(W)) begin
                            fill_d = fill_d + FILL_W'(1);
                        end
                    end
                    ST_VERIFY: begin
                        if (pred != rx) begin
                            mis = mis + MIS_W'(1);
                        end else if (good_d < GOOD_W'(LOCK_COUNT)) begin
                            good_d = good_d + GOOD_W'(1);
                        end
                        hist_d = {hist_d[W-2:0], rx};
                    end
                    ST_LOCKED: begin
                        // Flywheel: the prediction, not the line bit, feeds history.
                        if (pred != rx) begin
                            mis = mis + MIS_W'(1);
                        end
                        hist_d = {hist_d[W-2:0], pred};
                    end
                    default: ;
                endcase
            end

            case (state)
                ST_HUNT: begin
                    if ((fill_d == FILL_W'(W)) && (hist_d != '0)) begin
                        state_d = ST_VERIFY;
                        good_d  = '0;
                    end
                end
                ST_VERIFY: begin
                    if (mis != '0) begin
                        state_d = ST_HUNT;
                        fill_d  = '0;
                    end else if (good_d >= GOOD_W'(LOCK_COUNT)) begin
                        state_d    = ST_LOCKED;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end
                end
                ST_LOCKED: begin
                    bit_inc    = CW1'(B);
                    err_inc    = CW1'(mis);
                    bit_err_d  = (mis != '0);
                    win_bits_d = win_bits + WB_W'(B);
                    win_errs_d = win_errs + WE_W'(mis);
                    if (win_errs_d >= WE_W'(LOSS_THRESHOLD)) begin
                        state_d = ST_HUNT;
                        fill_d  = '0;
                    end else if (win_bits_d >= WB_W'(LOSS_WINDOW)) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    fill_d  = '0;
                end
            endcase
        end

        // A clear replaces the old value, so the beat's contribution still lands.
        bit_sum     = {1'b0, (clr_counts ? '0 : bit_count)} + bit_inc;
        err_sum     = {1'b0, (clr_counts ? '0 : err_count)} + err_inc;
        bit_count_d = bit_sum[CNT_WIDTH] ? '1 : bit_sum[CNT_WIDTH-1:0];
        err_count_d = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist      <= '0;
            fill      <= '0;
            good      <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
            locked    <= 1'b0;
            bit_err   <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            hist      <= hist_d;
            fill      <= fill_d;
            good      <= good_d;
            win_bits  <= win_bits_d;
            win_errs  <= win_errs_d;
            locked    <= (state_d == ST_LOCKED);
            bit_err   <= bit_err_d;
            err_count <= err_count_d;
            bit_count <= bit_count_d;
        end
    end

    assign sync_state = state;

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// Bench for galois_lfsr_checker: random-seeded recurrence streams with planted
// bit flips; expectations derived from stream positions and the lock/loss rules.
module tb_galois_lfsr_checker;

    logic        clk;
    logic        reset_n;
    logic        in1, v1, clr1;
    logic        locked1, bit_err1;
    logic [1:0]  sync1;
    logic [31:0] err1, bits1;
    logic [1:0]  in2;
    logic        v2, clr2;
    logic        locked2, bit_err2;
    logic [1:0]  sync2;
    logic [5:0]  err2, bits2;

    logic sb [0:2047];
    int errors = 0;
    int checks = 0;

    galois_lfsr_checker u1 (
        .clk(clk), .reset_n(reset_n), .in_bits(in1), .in_valid(v1), .clr_counts(clr1),
        .locked(locked1), .sync_state(sync1), .bit_err(bit_err1),
        .err_count(err1), .bit_count(bits1)
    );

    galois_lfsr_checker #(.LFSR_OUTPUT_BITS_PER_CLOCK(2), .CNT_WIDTH(6)) u2 (
        .clk(clk), .reset_n(reset_n), .in_bits(in2), .in_valid(v2), .clr_counts(clr2),
        .locked(locked2), .sync_state(sync2), .bit_err(bit_err2),
        .err_count(err2), .bit_count(bits2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference stream: nonzero random first 8 bits, then s[n] = XOR of s[n-1-t] for TAPS[t]=1.
    task automatic gen_stream();
        logic [7:0] taps;
        logic [7:0] seed;
        logic       x;
        taps = 8'h8E;
        seed = 8'($urandom_range(1, 255));
        for (int i = 0; i < 8; i++) sb[i] = seed[7-i];
        for (int i = 8; i < 2048; i++) begin
            x = 1'b0;
            for (int t = 0; t < 8; t++) if (taps[t]) x = x ^ sb[i-1-t];
            sb[i] = x;
        end
    endtask

    task automatic send1(input logic b, input logic v, input logic c);
        in1 = b; v1 = v; clr1 = c;
        @(posedge clk); #1;
    endtask

    task automatic send2(input logic [1:0] b, input logic v, input logic c);
        in2 = b; v2 = v; clr2 = c;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in1 = 0; v1 = 0; clr1 = 0; in2 = 0; v2 = 0; clr2 = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in1 = 1; v1 = 1; clr1 = 0; in2 = 2'b11; v2 = 1; clr2 = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (locked1 !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0d exp=0", locked1); end
        checks++; if (sync1 !== 2'd0) begin errors++; $display("FAIL reset_sync got=%0d exp=0", sync1); end
        checks++; if (bit_err1 !== 1'b0) begin errors++; $display("FAIL reset_bit_err got=%0d exp=0", bit_err1); end
        checks++; if (err1 !== 32'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err1); end
        checks++; if (bits1 !== 32'd0) begin errors++; $display("FAIL reset_bit_count got=%0d exp=0", bits1); end
        checks++; if (locked2 !== 1'b0 || sync2 !== 2'd0) begin errors++; $display("FAIL reset_b2 got=%0d/%0d exp=0/0", locked2, sync2); end
        reset_n = 1'b1;
    endtask

    task automatic test_clean_stream();
        int nb;
        do_reset();
        gen_stream();
        nb = 0;
        for (int n = 1; n <= 1000; n++) begin
            send1(sb[n-1], 1'b1, 1'b0);
            if (bit_err1) nb++;
            if (n == 7 || n == 8) begin
                checks++;
                if (sync1 !== ((n == 8) ? 2'd1 : 2'd0)) begin
                    errors++; $display("FAIL clean_sync_beat%0d got=%0d exp=%0d", n, sync1, (n == 8) ? 1 : 0);
                end
            end
            if (n == 23 || n == 24) begin
                checks++;
                if (locked1 !== (n == 24)) begin
                    errors++; $display("FAIL clean_lock_beat%0d got=%0d exp=%0d", n, locked1, (n == 24) ? 1 : 0);
                end
            end
        end
        checks++; if (err1 !== 32'd0) begin errors++; $display("FAIL clean_err_count got=%0d exp=0", err1); end
        checks++; if (bits1 !== 32'd976) begin errors++; $display("FAIL clean_bit_count got=%0d exp=976", bits1); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL clean_bit_err_pulses got=%0d exp=0", nb); end
        checks++; if (sync1 !== 2'd2 || locked1 !== 1'b1) begin errors++; $display("FAIL clean_locked_end got=%0d/%0d exp=2/1", sync1, locked1); end
    endtask

    task automatic test_single_flip();
        int f1, f2;
        logic b;
        do_reset();
        gen_stream();
        f1 = 30 + int'($urandom_range(0, 20));
        f2 = f1 + 10;
        for (int n = 1; n <= f2 + 3; n++) begin
            b = sb[n-1] ^ ((n == f1) || (n == f2));
            send1(b, 1'b1, 1'b0);
            if (n == f1) begin
                checks++; if (bit_err1 !== 1'b1) begin errors++; $display("FAIL flip1_bit_err got=%0d exp=1", bit_err1); end
                checks++; if (err1 !== 32'd1) begin errors++; $display("FAIL flip1_err_count got=%0d exp=1", err1); end
                checks++; if (locked1 !== 1'b1) begin errors++; $display("FAIL flip1_locked got=%0d exp=1", locked1); end
            end
            if (n == f1 + 1) begin
                checks++; if (bit_err1 !== 1'b0) begin errors++; $display("FAIL flip1_pulse_width got=%0d exp=0", bit_err1); end
            end
            if (n == f2) begin
                checks++; if (err1 !== 32'd2 || locked1 !== 1'b1) begin errors++; $display("FAIL flip2 err=%0d locked=%0d exp=2/1", err1, locked1); end
            end
        end
        checks++; if (bits1 !== 32'(f2 + 3 - 24)) begin errors++; $display("FAIL flip_bit_count got=%0d exp=%0d", bits1, f2 + 3 - 24); end
    endtask

    task automatic test_loss_of_lock();
        int k, st, last;
        logic fl;
        do_reset();
        gen_stream();
        k = int'($urandom_range(0, 2));
        st = 25 + 64 * k + int'($urandom_range(0, 20));
        last = st + 35;
        for (int n = 1; n <= last + 30; n++) begin
            fl = (n >= st) && (n <= last) && (((n - st) % 5) == 0);
            send1(sb[n-1] ^ fl, 1'b1, 1'b0);
            if (n == last - 5) begin
                checks++; if (locked1 !== 1'b1 || err1 !== 32'd7) begin errors++; $display("FAIL loss_seventh locked=%0d err=%0d exp=1/7", locked1, err1); end
            end
            if (n == last) begin
                checks++; if (locked1 !== 1'b0 || sync1 !== 2'd0) begin errors++; $display("FAIL loss_drop locked=%0d sync=%0d exp=0/0", locked1, sync1); end
                checks++; if (err1 !== 32'd8) begin errors++; $display("FAIL loss_err_count got=%0d exp=8", err1); end
            end
            if (n == last + 23) begin
                checks++; if (locked1 !== 1'b0) begin errors++; $display("FAIL loss_relock_early got=%0d exp=0", locked1); end
            end
            if (n == last + 24) begin
                checks++; if (locked1 !== 1'b1) begin errors++; $display("FAIL loss_relock got=%0d exp=1", locked1); end
                checks++; if (bits1 !== 32'(last - 24)) begin errors++; $display("FAIL loss_bit_hold got=%0d exp=%0d", bits1, last - 24); end
            end
        end
        checks++; if (err1 !== 32'd8) begin errors++; $display("FAIL loss_err_after got=%0d exp=8", err1); end
    endtask

    task automatic test_zeros_and_verify_flip();
        int bad, fb;
        do_reset();
        bad = 0;
        for (int n = 1; n <= 200; n++) begin
            send1(1'b0, 1'b1, 1'b0);
            if (sync1 !== 2'd0 || locked1 !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL zeros_left_hunt got=%0d exp=0", bad); end
        checks++; if (bits1 !== 32'd0) begin errors++; $display("FAIL zeros_bit_count got=%0d exp=0", bits1); end

        do_reset();
        gen_stream();
        fb = 9 + int'($urandom_range(0, 15));
        for (int n = 1; n <= fb + 26; n++) begin
            send1(sb[n-1] ^ (n == fb), 1'b1, 1'b0);
            if (n == fb - 1) begin
                checks++; if (sync1 !== 2'd1) begin errors++; $display("FAIL verify_state got=%0d exp=1", sync1); end
            end
            if (n == fb) begin
                checks++; if (sync1 !== 2'd0) begin errors++; $display("FAIL verify_flip_hunt got=%0d exp=0", sync1); end
            end
            if (n == fb + 23) begin
                checks++; if (locked1 !== 1'b0) begin errors++; $display("FAIL verify_relock_early got=%0d exp=0", locked1); end
            end
            if (n == fb + 24) begin
                checks++; if (locked1 !== 1'b1) begin errors++; $display("FAIL verify_relock got=%0d exp=1", locked1); end
            end
        end
        checks++; if (err1 !== 32'd0 || bits1 !== 32'd2) begin errors++; $display("FAIL verify_counts err=%0d bits=%0d exp=0/2", err1, bits1); end
    endtask

    task automatic test_async_reset();
        do_reset();
        gen_stream();
        for (int n = 1; n <= 30; n++) send1(sb[n-1] ^ (n == 28), 1'b1, 1'b0);
        checks++; if (err1 !== 32'd1 || bits1 !== 32'd6) begin errors++; $display("FAIL pre_async err=%0d bits=%0d exp=1/6", err1, bits1); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (locked1 !== 1'b0 || sync1 !== 2'd0) begin errors++; $display("FAIL async_state locked=%0d sync=%0d exp=0/0", locked1, sync1); end
        checks++; if (err1 !== 32'd0 || bits1 !== 32'd0) begin errors++; $display("FAIL async_counts err=%0d bits=%0d exp=0/0", err1, bits1); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back_b2();
        int vb, bad;
        logic [1:0] d;
        logic [1:0] prev;
        do_reset();
        gen_stream();
        vb = 0;
        bad = 0;
        for (int cyc = 0; vb < 52; cyc++) begin
            if (cyc % 2 == 1) begin
                prev = sync2;
                send2(2'($urandom_range(0, 3)), 1'b0, 1'b0);
                if (bit_err2 !== 1'b0 || sync2 !== prev) bad++;
            end else begin
                vb++;
                d = {sb[2*vb-2], sb[2*vb-1]};
                send2(d, 1'b1, 1'b0);
                if (vb == 11 || vb == 12) begin
                    checks++;
                    if (locked2 !== (vb == 12)) begin
                        errors++; $display("FAIL b2_lock_beat%0d got=%0d exp=%0d", vb, locked2, (vb == 12) ? 1 : 0);
                    end
                end
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2_idle_cycles got=%0d exp=0", bad); end
        checks++; if (bits2 !== 6'd63 || err2 !== 6'd0) begin errors++; $display("FAIL b2_saturate bits=%0d err=%0d exp=63/0", bits2, err2); end
        vb++;
        d = {sb[2*vb-2] ^ 1'b1, sb[2*vb-1]};
        send2(d, 1'b1, 1'b1);
        checks++; if (err2 !== 6'd1 || bits2 !== 6'd2) begin errors++; $display("FAIL b2_clr_beat err=%0d bits=%0d exp=1/2", err2, bits2); end
        checks++; if (bit_err2 !== 1'b1 || locked2 !== 1'b1) begin errors++; $display("FAIL b2_clr_flags bit_err=%0d locked=%0d exp=1/1", bit_err2, locked2); end
        vb++;
        d = {sb[2*vb-2], sb[2*vb-1]};
        send2(d, 1'b1, 1'b0);
        checks++; if (err2 !== 6'd1 || bits2 !== 6'd4) begin errors++; $display("FAIL b2_after_clr err=%0d bits=%0d exp=1/4", err2, bits2); end
    endtask

    initial begin
        reset_n = 1'b0;
        in1 = 0; v1 = 0; clr1 = 0; in2 = 0; v2 = 0; clr2 = 0;
        test_reset();
        test_clean_stream();
        test_single_flip();
        test_loss_of_lock();
        test_zeros_and_verify_flip();
        test_async_reset();
        test_back_to_back_b2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/galois_lfsr_checker.md
Name: galois_lfsr_checker

Overview:
- Receive-side PRBS checker for the galois_lfsr generator stream: consumes out/valid beats, self-synchronises to the sequence, then flags and counts bit mismatches.
- Checking is based on the linear recurrence of the sequence, so it is independent of the generator's seed and internal state.
- Used in loopback/link tests and the LFSR bench as a scoreboard, reporting lock status and error/bit counters.

Parameters:
- LFSR_WIDTH, 8: recurrence order W; history register width.
- LFSR_OUTPUT_BITS_PER_CLOCK, 1: bits per input beat B (1..W).
- TAPS, 8'h8E: recurrence mask. Predicted bit = XOR of hist[i] over all i with TAPS[i]=1. hist[0] is the newest bit. The default encodes x^8+x^6+x^5+x^4+1.
- LOCK_COUNT, 16: consecutive good bits in VERIFY required to lock.
- LOSS_WINDOW, 64: bits per loss-detection window in LOCKED.
- LOSS_THRESHOLD, 8: errors within one window that force loss of lock.
- CNT_WIDTH, 32: width of err_count and bit_count.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- in_bits  in  B  received bits; MSB is the earliest bit in time
- in_valid  in  1  beat qualifier; in_bits is ignored when low
- clr_counts  in  1  synchronous clear of err_count and bit_count
- locked  out  1  high while in LOCKED
- sync_state  out  2  0=HUNT, 1=VERIFY, 2=LOCKED
- bit_err  out  1  one-cycle pulse: at least one mismatch in the previous LOCKED beat
- err_count  out  CNT_WIDTH  mismatched bits in LOCKED; saturating
- bit_count  out  CNT_WIDTH  bits checked in LOCKED; saturating

Behaviour:
- Reset values:
  - State HUNT; hist, fill, good and window counters = 0.
  - Outputs: locked=0, sync_state=0, bit_err=0, err_count=0, bit_count=0.
  - Reset mid-operation aborts immediately, whatever the state.
- Beat processing:
  - All B bits of a beat are processed serially MSB-first, combinationally, in one cycle.
  - For each bit: p = predicted bit; r = received bit; mismatch = p^r (only when checking).
  - Mode is fixed at the start of the beat. State transitions take effect for the next beat. Leftover bits of a transition beat follow the old mode.
  - All outputs are registered; latency is 1 cycle after the in_valid beat.
- HUNT:
  - r shifts into hist; no checking.
  - fill counts bits, saturating at W.
  - If fill==W and hist!=0 at beat end → VERIFY, good=0.
  - If hist==0 (all-zero stream), stay in HUNT indefinitely. Lock is never declared on zeros.
- VERIFY:
  - Compare each bit; r shifts into hist (self-sync).
  - good accumulates matching bits.
  - Any mismatch in the beat → HUNT, fill=0.
  - If good>=LOCK_COUNT at beat end with no mismatch → LOCKED; window counters are cleared.
- LOCKED (flywheel):
  - p, not r, shifts into hist, so one flipped line bit yields exactly one error.
  - bit_count += B; err_count += mismatches in the beat; both saturate at all-ones.
  - bit_err=1 the next cycle if mismatches>0.
  - Window bit counter += B; window error counter += mismatches.
  - If window errors >= LOSS_THRESHOLD → HUNT, fill=0. locked falls the cycle after that beat. Counters hold their values.
  - Otherwise, when window bits >= LOSS_WINDOW, both window counters reset to 0.
- clr_counts:
  - Has priority over increment. A cleared counter is loaded with that beat's contribution, not 0+old.
  - Affects neither state nor window counters.
- in_valid low: no state change; bit_err=0.
- Timing from reset with a clean stream: locked rises the cycle after the beat holding bit W+LOCK_COUNT. That is bit 24 for the defaults.

Test Plan:
- Reset hold → all outputs 0, sync_state=0. Assert reset_n low while LOCKED → locked=0 and counters=0 asynchronously.
- Clean stream (defaults; generator polynomial x^8+x^6+x^5+x^4+1, seed 8'h01), in_valid always high → sync_state 1 after beat 8, locked after beat 24; after 1000 beats err_count=0, bit_count=976.
- Single bit flip while LOCKED → one bit_err pulse, err_count=1, locked stays 1. Next flip 10 beats later → err_count=2.
- Eight flips within 64 bits → locked falls the cycle after the 8th flip. Clean bits follow → relock 24 beats later; err_count=8.
- All-zero input for 200 beats → sync_state stays 0, locked=0, bit_count=0. A flip during VERIFY → back to HUNT, relock 24 beats after the last error.
- B=2 config with in_valid toggling every other cycle → lock after beat 12. clr_counts plus one error in the same beat → err_count=1, bit_count=2.
